// File: rtl/pc_fetch_gen_pkg.sv
// Shared types and defaults for the IF-stage fetch-address generator.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int XLEN_DEF = 32;
    localparam int INC_DEF  = 4;

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Fetch-request handshake, redirect inputs and misalign reporting bundled between
// the fetch generator (master) and the surrounding IF stage / imem (slave).
interface pc_fetch_gen_if
    import rv_fetch_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NUM_RDR = 3
)();

    logic                    stall;
    logic [NUM_RDR-1:0]      redir_valid;
    logic [NUM_RDR*XLEN-1:0] redir_target;
    logic                    fetch_valid;
    logic                    fetch_ready;
    logic [XLEN-1:0]         fetch_pc;
    logic [XLEN-1:0]         fetch_pc_nxt;
    logic [NUM_RDR-1:0]      redir_taken;
    logic                    misalign_err;
    logic [XLEN-1:0]         misalign_addr;

    modport master (
        input  stall, redir_valid, redir_target, fetch_ready,
        output fetch_valid, fetch_pc, fetch_pc_nxt, redir_taken, misalign_err, misalign_addr
    );

    modport slave (
        output stall, redir_valid, redir_target, fetch_ready,
        input  fetch_valid, fetch_pc, fetch_pc_nxt, redir_taken, misalign_err, misalign_addr
    );

endinterface

// File: rtl/pc_fetch_gen_redir_arb.sv
// Fixed-priority redirect arbiter: lowest-index valid source wins; also flags
// a winning target whose low IALIGN bits are not zero.
module pc_redir_arb
    import rv_fetch_pkg::*;
#(
    parameter int NUM_RDR = 3,
    parameter int XLEN    = XLEN_DEF,
    parameter int IALIGN  = 2
)(
    input  logic [NUM_RDR-1:0]      i_redir_valid,
    input  logic [NUM_RDR*XLEN-1:0] i_redir_target,
    output logic                    o_any_redir,
    output logic [NUM_RDR-1:0]      o_redir_taken,
    output logic [XLEN-1:0]         o_target,
    output logic                    o_misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << IALIGN) - XLEN'(1);

    // Scan from lowest priority upward so the last hit is the highest-priority source.
    always_comb begin
        o_any_redir   = 1'b0;
        o_redir_taken = '0;
        o_target      = '0;
        for (int i = NUM_RDR - 1; i >= 0; i--) begin
            if (i_redir_valid[i]) begin
                o_any_redir      = 1'b1;
                o_redir_taken    = '0;
                o_redir_taken[i] = 1'b1;
                o_target         = i_redir_target[i*XLEN +: XLEN];
            end
        end
    end

    assign o_misaligned = o_any_redir & (|(o_target & ALIGN_MASK));

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC register and BOOT/RUN/HALT control at the head of the IF stage;
// presents fetch_pc to imem over valid/ready and applies prioritised redirects.
module pc_fetch_gen
    import rv_fetch_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              INC       = INC_DEF,
    parameter int              IALIGN    = 2,
    parameter int              NUM_RDR   = 3
)(
    input  logic           clk,
    input  logic           rst_n,
    pc_fetch_gen_if.master fetch_if
);

    state_t             r_state;
    state_t             w_next_state;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    w_pc_inc;
    logic [XLEN-1:0]    w_pc_next;
    logic               r_misalign_err;
    logic [XLEN-1:0]    r_misalign_addr;
    logic               w_any_redir;
    logic               w_misaligned;
    logic [NUM_RDR-1:0] w_redir_taken;
    logic [XLEN-1:0]    w_redir_target;
    logic               w_fetch_valid;
    logic               w_accept;

    pc_redir_arb #(
        .NUM_RDR (NUM_RDR),
        .XLEN    (XLEN),
        .IALIGN  (IALIGN)
    ) u_arb (
        .i_redir_valid  (fetch_if.redir_valid),
        .i_redir_target (fetch_if.redir_target),
        .o_any_redir    (w_any_redir),
        .o_redir_taken  (w_redir_taken),
        .o_target       (w_redir_target),
        .o_misaligned   (w_misaligned)
    );

    assign w_pc_inc = r_pc + XLEN'(INC);
    assign w_accept = w_fetch_valid & fetch_if.fetch_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A redirect overrides everything, including a HALT; only its alignment picks RUN vs HALT.
    always_comb begin
        w_next_state = r_state;
        if (w_any_redir) begin
            w_next_state = w_misaligned ? HALT : RUN;
        end else if (r_state == BOOT) begin
            w_next_state = RUN;
        end
    end

    always_comb begin
        w_fetch_valid = (r_state == RUN) & ~fetch_if.stall;
    end

    // Redirect beats the handshake: an accepted fetch in the same cycle still loads the target.
    always_comb begin
        w_pc_next = r_pc;
        if (w_any_redir) begin
            if (!w_misaligned) begin
                w_pc_next = w_redir_target;
            end
        end else if (w_accept) begin
            w_pc_next = w_pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign_err  <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign_err <= w_misaligned;
            if (w_misaligned) begin
                r_misalign_addr <= w_redir_target;
            end
        end
    end

    assign fetch_if.fetch_valid   = w_fetch_valid;
    assign fetch_if.fetch_pc      = r_pc;
    assign fetch_if.fetch_pc_nxt  = w_pc_inc;
    assign fetch_if.redir_taken   = w_redir_taken;
    assign fetch_if.misalign_err  = r_misalign_err;
    assign fetch_if.misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen: literal expectations per scenario plus a
// behavioural model compared against every output on each falling edge.
module tb_pc_fetch_gen;

    logic clk  = 1'b0;
    logic rstN = 1'b1;

    int testsRun    = 0;
    int testsFailed = 0;

    pc_fetch_gen_if #(.XLEN(32), .NUM_RDR(3)) bus();

    pc_fetch_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0),
        .INC       (4),
        .IALIGN    (2),
        .NUM_RDR   (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .fetch_if (bus)
    );

    always #5 clk = ~clk;

    // Abstract model: the PC, whether the boot cycle is over, whether we are halted.
    logic [31:0] mPc     = 32'h0;
    logic [31:0] mAddr   = 32'h0;
    logic        mErr    = 1'b0;
    logic        mBooted = 1'b0;
    logic        mHalted = 1'b0;
    logic [31:0] mTgt;

    function automatic logic [2:0] lowestSet(input logic [2:0] v);
        return v & 3'(~v + 3'd1);
    endfunction

    function automatic logic [31:0] winnerTarget(input logic [2:0] v, input logic [95:0] t);
        case (lowestSet(v))
            3'b001:  return t[31:0];
            3'b010:  return t[63:32];
            3'b100:  return t[95:64];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [95:0] packT(input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
        return {t2, t1, t0};
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mPc = 32'h0; mAddr = 32'h0; mErr = 1'b0; mBooted = 1'b0; mHalted = 1'b0;
        end else begin
            mErr = 1'b0;
            if (bus.redir_valid != 3'b000) begin
                mTgt    = winnerTarget(bus.redir_valid, bus.redir_target);
                mBooted = 1'b1;
                if (mTgt % 4 != 0) begin
                    mHalted = 1'b1; mErr = 1'b1; mAddr = mTgt;
                end else begin
                    mHalted = 1'b0; mPc = mTgt;
                end
            end else if (!mBooted) begin
                mBooted = 1'b1;
            end else if (!mHalted && !bus.stall && bus.fetch_ready) begin
                mPc = mPc + 32'd4;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model valid", 32'(bus.fetch_valid), 32'(mBooted && !mHalted && !bus.stall));
        checkOutput("model pc", bus.fetch_pc, mPc);
        checkOutput("model pc_nxt", bus.fetch_pc_nxt, mPc + 32'd4);
        checkOutput("model taken", 32'(bus.redir_taken), 32'(lowestSet(bus.redir_valid)));
        checkOutput("model err", 32'(bus.misalign_err), 32'(mErr));
        checkOutput("model addr", bus.misalign_addr, mAddr);
    end

    task automatic applyStimulus(input logic s, input logic [2:0] v, input logic [95:0] t, input logic r);
        @(posedge clk);
        #1;
        bus.stall        = s;
        bus.redir_valid  = v;
        bus.redir_target = t;
        bus.fetch_ready  = r;
    endtask

    task automatic cycleCheck(input string name, input logic expValid, input logic [31:0] expPc);
        @(negedge clk);
        checkOutput({name, " valid"}, 32'(bus.fetch_valid), 32'(expValid));
        checkOutput({name, " pc"}, bus.fetch_pc, expPc);
    endtask

    initial begin
        bus.stall        = 1'b0;
        bus.redir_valid  = 3'b000;
        bus.redir_target = '0;
        bus.fetch_ready  = 1'b1;
        #1 rstN = 1'b0;
        #2;
        checkOutput("reset valid", 32'(bus.fetch_valid), 32'h0);
        checkOutput("reset pc", bus.fetch_pc, 32'h0);
        checkOutput("reset pc_nxt", bus.fetch_pc_nxt, 32'h4);
        checkOutput("reset err", 32'(bus.misalign_err), 32'h0);
        checkOutput("reset addr", bus.misalign_addr, 32'h0);

        // Sequential fetch after the boot bubble
        @(posedge clk); #1; rstN = 1'b1;
        cycleCheck("boot", 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) cycleCheck("seq", 1'b1, 32'(4 * k));

        // imem back-pressure holds the request
        applyStimulus(1'b0, 3'b000, '0, 1'b0);
        for (int k = 0; k < 3; k++) cycleCheck("backpressure", 1'b1, 32'h10);
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        cycleCheck("bp release", 1'b1, 32'h10);
        cycleCheck("bp advance", 1'b1, 32'h14);

        // Hazard stall
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        applyStimulus(1'b1, 3'b000, '0, 1'b1);
        cycleCheck("stall1", 1'b0, 32'h20);
        applyStimulus(1'b1, 3'b000, '0, 1'b1);
        cycleCheck("stall2", 1'b0, 32'h20);
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        cycleCheck("stall release", 1'b1, 32'h20);

        // Priority arbitration, redirect coincident with a handshake
        applyStimulus(1'b0, 3'b110, packT(32'h0, 32'h100, 32'h200), 1'b1);
        @(negedge clk);
        checkOutput("arb taken", 32'(bus.redir_taken), 32'h2);
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        cycleCheck("arb target", 1'b1, 32'h100);

        // Misaligned redirect halts, aligned redirect recovers
        applyStimulus(1'b0, 3'b001, packT(32'h102, 32'h0, 32'h0), 1'b1);
        cycleCheck("mis req", 1'b1, 32'h104);
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        cycleCheck("mis halt", 1'b0, 32'h104);
        checkOutput("mis err", 32'(bus.misalign_err), 32'h1);
        checkOutput("mis addr", bus.misalign_addr, 32'h102);
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        cycleCheck("mis hold", 1'b0, 32'h104);
        checkOutput("mis pulse end", 32'(bus.misalign_err), 32'h0);
        checkOutput("mis addr hold", bus.misalign_addr, 32'h102);
        applyStimulus(1'b0, 3'b001, packT(32'h80, 32'h0, 32'h0), 1'b1);
        cycleCheck("halt redir", 1'b0, 32'h104);
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        cycleCheck("halt exit", 1'b1, 32'h80);

        // Wrap at top of address space, then async reset mid-stall
        applyStimulus(1'b0, 3'b100, packT(32'h0, 32'h0, 32'hFFFF_FFFC), 1'b1);
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        cycleCheck("wrap top", 1'b1, 32'hFFFF_FFFC);
        checkOutput("wrap nxt", bus.fetch_pc_nxt, 32'h0);
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        cycleCheck("wrap zero", 1'b1, 32'h0);
        applyStimulus(1'b1, 3'b000, '0, 1'b1);
        cycleCheck("pre-reset stall", 1'b0, 32'h4);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async reset pc", bus.fetch_pc, 32'h0);
        checkOutput("async reset valid", 32'(bus.fetch_valid), 32'h0);

        // Redirect during the boot cycle
        applyStimulus(1'b0, 3'b100, packT(32'h0, 32'h0, 32'h40), 1'b1);
        rstN = 1'b1;
        cycleCheck("boot redir", 1'b0, 32'h0);
        checkOutput("boot taken", 32'(bus.redir_taken), 32'h4);
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        cycleCheck("boot redir target", 1'b1, 32'h40);

        // Mixed traffic checked by the model only
        for (int k = 0; k < 24; k++) begin
            applyStimulus($urandom_range(0, 3) == 0,
                          ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                          packT({$urandom_range(0, 255), 2'b00} & 32'h3FC, 32'h500, {$urandom_range(0, 3), 2'b10}),
                          1'($urandom_range(0, 1)));
        end
        applyStimulus(1'b0, 3'b000, '0, 1'b1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
